// File: rtl/kbd_pkg.sv
// Shared types and constants for the C64 keyboard matrix block.
package kbd_pkg;

  // PS/2 scancode decoder state
  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StSkip
  } kbd_state_e;

  // PS/2 set-2 prefix and status bytes
  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_AA = 8'hAA;
  localparam logic [7:0] PS2_FA = 8'hFA;

  // Matrix coordinate: row is the PA bit, col is the PB bit
  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } kbd_coord_t;

endpackage

// File: rtl/c64_keymap.sv
// Combinational ROM: {ext, PS/2 set-2 code} -> C64 matrix position.
module c64_keymap
  import kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output kbd_coord_t coord
);

  // One entry per C64 key; anything else is a miss
  always_comb begin
    hit   = 1'b1;
    coord = '0;
    unique case ({ext, code})
      // Row 0: DEL RETURN CRSR-LR F7 F1 F3 F5 CRSR-UD
      9'h066: coord = '{row: 3'd0, col: 3'd0};
      9'h05A: coord = '{row: 3'd0, col: 3'd1};
      9'h174: coord = '{row: 3'd0, col: 3'd2};
      9'h083: coord = '{row: 3'd0, col: 3'd3};
      9'h005: coord = '{row: 3'd0, col: 3'd4};
      9'h004: coord = '{row: 3'd0, col: 3'd5};
      9'h003: coord = '{row: 3'd0, col: 3'd6};
      9'h172: coord = '{row: 3'd0, col: 3'd7};
      // Row 1: 3 W A 4 Z S E LSHIFT
      9'h026: coord = '{row: 3'd1, col: 3'd0};
      9'h01D: coord = '{row: 3'd1, col: 3'd1};
      9'h01C: coord = '{row: 3'd1, col: 3'd2};
      9'h025: coord = '{row: 3'd1, col: 3'd3};
      9'h01A: coord = '{row: 3'd1, col: 3'd4};
      9'h01B: coord = '{row: 3'd1, col: 3'd5};
      9'h024: coord = '{row: 3'd1, col: 3'd6};
      9'h012: coord = '{row: 3'd1, col: 3'd7};
      // Row 2: 5 R D 6 C F T X
      9'h02E: coord = '{row: 3'd2, col: 3'd0};
      9'h02D: coord = '{row: 3'd2, col: 3'd1};
      9'h023: coord = '{row: 3'd2, col: 3'd2};
      9'h036: coord = '{row: 3'd2, col: 3'd3};
      9'h021: coord = '{row: 3'd2, col: 3'd4};
      9'h02B: coord = '{row: 3'd2, col: 3'd5};
      9'h02C: coord = '{row: 3'd2, col: 3'd6};
      9'h022: coord = '{row: 3'd2, col: 3'd7};
      // Row 3: 7 Y G 8 B H U V
      9'h03D: coord = '{row: 3'd3, col: 3'd0};
      9'h035: coord = '{row: 3'd3, col: 3'd1};
      9'h034: coord = '{row: 3'd3, col: 3'd2};
      9'h03E: coord = '{row: 3'd3, col: 3'd3};
      9'h032: coord = '{row: 3'd3, col: 3'd4};
      9'h033: coord = '{row: 3'd3, col: 3'd5};
      9'h03C: coord = '{row: 3'd3, col: 3'd6};
      9'h02A: coord = '{row: 3'd3, col: 3'd7};
      // Row 4: 9 I J 0 M K O N
      9'h046: coord = '{row: 3'd4, col: 3'd0};
      9'h043: coord = '{row: 3'd4, col: 3'd1};
      9'h03B: coord = '{row: 3'd4, col: 3'd2};
      9'h045: coord = '{row: 3'd4, col: 3'd3};
      9'h03A: coord = '{row: 3'd4, col: 3'd4};
      9'h042: coord = '{row: 3'd4, col: 3'd5};
      9'h044: coord = '{row: 3'd4, col: 3'd6};
      9'h031: coord = '{row: 3'd4, col: 3'd7};
      // Row 5: + P L - . : @ ,
      9'h04E: coord = '{row: 3'd5, col: 3'd0};
      9'h04D: coord = '{row: 3'd5, col: 3'd1};
      9'h04B: coord = '{row: 3'd5, col: 3'd2};
      9'h055: coord = '{row: 3'd5, col: 3'd3};
      9'h049: coord = '{row: 3'd5, col: 3'd4};
      9'h04C: coord = '{row: 3'd5, col: 3'd5};
      9'h054: coord = '{row: 3'd5, col: 3'd6};
      9'h041: coord = '{row: 3'd5, col: 3'd7};
      // Row 6: pound * ; HOME RSHIFT = up-arrow /
      9'h05D: coord = '{row: 3'd6, col: 3'd0};
      9'h05B: coord = '{row: 3'd6, col: 3'd1};
      9'h052: coord = '{row: 3'd6, col: 3'd2};
      9'h16C: coord = '{row: 3'd6, col: 3'd3};
      9'h059: coord = '{row: 3'd6, col: 3'd4};
      9'h079: coord = '{row: 3'd6, col: 3'd5};
      9'h00D: coord = '{row: 3'd6, col: 3'd6};
      9'h04A: coord = '{row: 3'd6, col: 3'd7};
      // Row 7: 1 left-arrow CTRL 2 SPACE C= Q RUN/STOP
      9'h016: coord = '{row: 3'd7, col: 3'd0};
      9'h00E: coord = '{row: 3'd7, col: 3'd1};
      9'h014: coord = '{row: 3'd7, col: 3'd2};
      9'h01E: coord = '{row: 3'd7, col: 3'd3};
      9'h029: coord = '{row: 3'd7, col: 3'd4};
      9'h011: coord = '{row: 3'd7, col: 3'd5};
      9'h015: coord = '{row: 3'd7, col: 3'd6};
      9'h076: coord = '{row: 3'd7, col: 3'd7};
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/c64_keyboard_matrix.sv
// PS/2 set-2 scancodes -> 8x8 C64 key matrix driving the keyboard CIA ports.
module c64_keyboard_matrix
  import kbd_pkg::*;
#(
  parameter logic [8:0]  RESTORE_CODE = 9'h17D,
  parameter int unsigned SKIP_LEN     = 7
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       key_strobe,
  input  logic [7:0] key_code,
  input  logic [7:0] pa_out,
  input  logic [7:0] pb_out,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       restore_n,
  output logic       busy
);

  localparam int unsigned SkipW = (SKIP_LEN < 2) ? 1 : $clog2(SKIP_LEN + 1);

  kbd_state_e       state_q, state_d;
  logic [SkipW-1:0] cnt_q, cnt_d;
  logic [7:0][7:0]  key_q;          // key_q[row][col], 1 = pressed
  logic [7:0]       pa_in_q, pb_in_q;
  logic             restore_n_q;

  logic       ev_valid, ev_make, ev_ext, clr_all;
  logic       hit, is_restore;
  kbd_coord_t coord;

  c64_keymap u_keymap (
    .ext   (ev_ext),
    .code  (key_code),
    .hit   (hit),
    .coord (coord)
  );

  assign is_restore = ({ev_ext, key_code} == RESTORE_CODE);

  // Prefix decoder: classify each strobed byte and emit make/break events
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_ext   = 1'b0;
    clr_all  = 1'b0;
    if (key_strobe) begin
      unique case (state_q)
        StIdle: begin
          if (key_code == PS2_E0) begin
            state_d = StExt;
          end else if (key_code == PS2_F0) begin
            state_d = StBrk;
          end else if (key_code == PS2_E1) begin
            state_d = StSkip;
            cnt_d   = SkipW'(SKIP_LEN);
          end else if (key_code == PS2_AA) begin
            clr_all = 1'b1;
          end else if (key_code != PS2_FA) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
          end
        end
        StExt: begin
          ev_ext = 1'b1;
          if (key_code == PS2_F0) begin
            state_d = StExtBrk;
          end else if (key_code != PS2_E0) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          // A second prefix here is a protocol error: drop the sequence
          state_d  = StIdle;
          ev_valid = (key_code != PS2_E0) && (key_code != PS2_F0);
        end
        StExtBrk: begin
          ev_ext   = 1'b1;
          ev_valid = 1'b1;
          state_d  = StIdle;
        end
        StSkip: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= SkipW'(1)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Decoder state and skip counter
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Key matrix and RESTORE level; RESTORE bypasses the matrix entirely
  always_ff @(posedge clk) begin
    if (!res_n || clr_all) begin
      key_q       <= '0;
      restore_n_q <= 1'b1;
    end else if (ev_valid) begin
      if (is_restore) begin
        restore_n_q <= ~ev_make;
      end else if (hit) begin
        key_q[coord.row][coord.col] <= ev_make;
      end
    end
  end

  // Registered port resolution in both directions (row->column and column->row)
  always_ff @(posedge clk) begin
    if (!res_n) begin
      pa_in_q <= 8'hFF;
      pb_in_q <= 8'hFF;
    end else begin
      for (int c = 0; c < 8; c++) begin
        logic any;
        any = 1'b0;
        for (int r = 0; r < 8; r++) any = any | (key_q[r][c] & ~pa_out[r]);
        pb_in_q[c] <= ~any;
      end
      for (int r = 0; r < 8; r++) begin
        pa_in_q[r] <= ~|(key_q[r] & ~pb_out);
      end
    end
  end

  assign pa_in     = pa_in_q;
  assign pb_in     = pb_in_q;
  assign restore_n = restore_n_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// Directed self-checking bench for c64_keyboard_matrix.
module tb_c64_keyboard_matrix;

  logic       clk = 1'b0;
  logic       res_n;
  logic       key_strobe;
  logic [7:0] key_code;
  logic [7:0] pa_out, pb_out;
  logic [7:0] pa_in, pb_in;
  logic       restore_n, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c64_keyboard_matrix dut (
    .clk        (clk),
    .res_n      (res_n),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .pa_out     (pa_out),
    .pb_out     (pb_out),
    .pa_in      (pa_in),
    .pb_in      (pb_in),
    .restore_n  (restore_n),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe one byte; returns at the falling edge after the consuming posedge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    key_strobe = 1'b1;
    key_code   = b;
    @(negedge clk);
    key_strobe = 1'b0;
    key_code   = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    res_n      = 1'b0;
    key_strobe = 1'b0;
    key_code   = 8'h00;
    pa_out     = 8'hFF;
    pb_out     = 8'hFF;
    step(3);
    chk("rst_pa_in", pa_in, 8'hFF);
    chk("rst_pb_in", pb_in, 8'hFF);
    chk("rst_restore", {7'd0, restore_n}, 8'h01);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    res_n = 1'b1;
    step(1);

    // Make A (row 1, col 2): two-clock latency from strobe to pb_in
    pa_out = 8'hFD;
    send(8'h1C);
    chk("a_lat1", pb_in, 8'hFF);
    step(1);
    chk("a_make", pb_in, 8'hFB);
    pa_out = 8'hFF;
    step(2);
    chk("a_unsel", pb_in, 8'hFF);

    // Break A
    pa_out = 8'hFD;
    send(8'hF0);
    chk("brk_busy", {7'd0, busy}, 8'h01);
    send(8'h1C);
    chk("brk_idle", {7'd0, busy}, 8'h00);
    step(2);
    chk("a_break", pb_in, 8'hFF);

    // Reverse scan: Space (7,4) and Return (0,1)
    pa_out = 8'hFF;
    send(8'h29);
    send(8'h5A);
    pb_out = 8'hEF;
    step(2);
    chk("rev_col4", pa_in, 8'h7F);
    pb_out = 8'hED;
    step(2);
    chk("rev_col14", pa_in, 8'h7E);
    pa_out = 8'h7E;
    step(2);
    chk("fwd_rows07", pb_in, 8'hED);
    send(8'hF0); send(8'h29);
    send(8'hF0); send(8'h5A);
    pa_out = 8'hFF;
    pb_out = 8'h00;
    step(2);
    chk("rev_released", pa_in, 8'hFF);

    // RESTORE on E0 7D, never through the matrix
    send(8'hE0);
    chk("ext_busy", {7'd0, busy}, 8'h01);
    send(8'h7D);
    chk("restore_make", {7'd0, restore_n}, 8'h00);
    step(2);
    chk("restore_no_mtx", pa_in, 8'hFF);
    send(8'hE0); send(8'hF0);
    chk("extbrk_busy", {7'd0, busy}, 8'h01);
    send(8'h7D);
    chk("restore_break", {7'd0, restore_n}, 8'h01);

    // Extended code with no keymap entry
    send(8'hE0); send(8'h75);
    step(2);
    chk("ext_miss", pa_in, 8'hFF);

    // Pause: everything after E1 is swallowed
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      chk($sformatf("pause_busy%0d", i), {7'd0, busy}, (i < 7) ? 8'h01 : 8'h00);
    end
    step(2);
    chk("pause_mtx", pa_in, 8'hFF);

    // Reset in the middle of a Left Shift break
    pb_out = 8'hFF;
    pa_out = 8'hFD;
    send(8'h12);
    step(2);
    chk("lshift_make", pb_in, 8'h7F);
    send(8'hF0);
    res_n = 1'b0;
    step(1);
    res_n = 1'b1;
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    step(2);
    chk("midrst_mtx", pb_in, 8'hFF);
    send(8'h1C);
    step(2);
    chk("postrst_a", pb_in, 8'hFB);

    // Self-test byte AA clears matrix and releases RESTORE
    send(8'h12);
    send(8'hE0); send(8'h7D);
    step(2);
    chk("shift_a", pb_in, 8'h7B);
    chk("restore_held", {7'd0, restore_n}, 8'h00);
    send(8'hFA);
    step(2);
    chk("ack_noop", pb_in, 8'h7B);
    send(8'hAA);
    chk("aa_restore", {7'd0, restore_n}, 8'h01);
    step(2);
    chk("aa_clear", pb_in, 8'hFF);

    // Idempotent make, then a single break releases
    send(8'h1C); send(8'h1C);
    step(2);
    chk("idem_make", pb_in, 8'hFB);
    send(8'hF0); send(8'h1C);
    step(2);
    chk("idem_break", pb_in, 8'hFF);

    // Double prefix in break state is dropped without an event
    send(8'h1C);
    send(8'hF0); send(8'hF0);
    chk("brk_err_idle", {7'd0, busy}, 8'h00);
    step(2);
    chk("brk_err_keep", pb_in, 8'hFB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
